core_bist_ctrl: RTL
===================

// Module: core_bist_ctrl
// PURPOSE
//  Stimulus/response controller for the 14-input, 8-output mapped combinational core.
//  - Drives the core primary inputs from an LFSR pattern generator.
//  - Folds the core primary outputs into a MISR signature.
//  - Compares the final signature against an expected value and reports pass/fail.
//  Sits beside the core in the eval harness, so an optimised netlist can be checked
//  against the golden one by comparing signatures.
// PARAMETERS
//  N_IN      14        width of pi (core inputs)
//  N_OUT     8         width of po (core outputs)
//  N_PAT     256       patterns per run; legal range 1..65535
//  SETTLE    2         cycles pi is held before po is captured; must be >=1
//  LFSR_SEED 14'h0001  LFSR load value; a value of 0 is replaced by 1
//  LFSR_POLY 14'h3005  Galois feedback mask (x^14+x^13+x^12+x^2+1)
//  MISR_POLY 8'h1D     MISR feedback mask (x^8+x^4+x^3+x^2+1)
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      1-cycle pulse; honoured only in IDLE or DONE
//  abort      in   1      synchronous; returns to IDLE from any state
//  exp_sig    in   N_OUT  expected signature; sampled in the DONE-entry cycle
//  po         in   N_OUT  core outputs
//  pi         out  N_IN   core inputs, registered
//  busy       out  1      high in APPLY and CAPTURE
//  done       out  1      high in DONE
//  signature  out  N_OUT  final MISR value, valid while done=1
//  pass       out  1      signature==exp_sig, valid while done=1
// BEHAVIOUR
//  Reset values
//  - pi=0, busy=0, done=0, signature=0, pass=0.
//  - lfsr=LFSR_SEED, misr=0, pat_cnt=0, settle_cnt=0, state=IDLE.
//  FSM states: IDLE, APPLY, CAPTURE, DONE.
//  IDLE/DONE + start
//  - lfsr<=SEED, pi<=SEED, misr<=0, pat_cnt<=0, settle_cnt<=0, done<=0, pass<=0.
//  - Next state APPLY.
//  APPLY
//  - pi holds; settle_cnt increments.
//  - When settle_cnt==SETTLE-1: settle_cnt<=0, go to CAPTURE.
//  CAPTURE (1 cycle)
//  - misr <= {misr[6:0],1'b0} ^ (misr[7]?MISR_POLY:0) ^ po.
//  - lfsr <= {lfsr[12:0],1'b0} ^ (lfsr[13]?LFSR_POLY:0); pi <= new lfsr.
//  - If pat_cnt==N_PAT-1: go to DONE, signature<=new misr, pass<=(new misr==exp_sig).
//  - Otherwise pat_cnt++ and go to APPLY.
//  DONE
//  - done=1; signature and pass held.
//  - pi is left at the final advanced LFSR value until the next start or abort.
//  Timing
//  - Each pattern is stable on pi for SETTLE+1 cycles before po is captured.
//  - A run occupies N_PAT*(SETTLE+1) cycles from the start edge to the first cycle with done=1.
//  Boundary cases
//  - start while busy: ignored.
//  - start and abort in the same cycle: abort wins.
//  - abort: go to IDLE with pi=0, busy=0, done=0, pass=0; signature keeps its prior value.
//  - rst_n low mid-run: immediate return to the reset values; no partial result is reported.
//  - N_PAT=1: exactly one CAPTURE, signature equals the sampled po.
//  - pat_cnt is 16 bits wide and never wraps within a legal N_PAT.
// TESTING
//  1. N_PAT=1, po tied 8'hA5, exp_sig=8'hA5, start -> done after SETTLE+1 cycles,
//     signature=8'hA5, pass=1.
//  2. N_PAT=2, po tied 8'hA5, exp_sig=8'h00 -> signature=8'hF2, pass=0.
//  3. Seed 1, N_PAT=16 -> pi patterns are 1<<k for k=0..13, then 14'h3005 as the 15th pattern;
//     each pattern is held SETTLE+1 cycles.
//  4. Assert abort in the APPLY of pattern 3 -> IDLE next cycle with pi=0, done=0.
//     A fresh start then reproduces the test 2 signature.
//  5. start pulsed mid-run -> no restart, run length unchanged.
//     start in DONE -> clean rerun with an identical signature.
//  6. Pull rst_n low mid-CAPTURE -> all outputs return to reset values asynchronously.
//     Release rst_n, then start -> normal run.

Source files
------------

// File: rtl/core_bist_ctrl.sv
// LFSR-driven stimulus and MISR-compacted response controller for a combinational core.
// A run applies N_PAT patterns and holds each for SETTLE+1 cycles, then reports the final signature and pass/fail.
module core_bist_ctrl #(
  parameter int              N_IN      = 14,
  parameter int              N_OUT     = 8,
  parameter int              N_PAT     = 256,
  parameter int              SETTLE    = 2,
  parameter logic [N_IN-1:0] LFSR_SEED = 14'h0001,
  parameter logic [N_IN-1:0] LFSR_POLY = 14'h3005,
  parameter logic [N_OUT-1:0] MISR_POLY = 8'h1D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] exp_sig,
  input  logic [N_OUT-1:0] po,
  output logic [N_IN-1:0]  pi,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature,
  output logic             pass
);

  // state   | meaning
  // IDLE    | waiting for start, pi parked at 0
  // APPLY   | pattern held on pi while the core settles
  // CAPTURE | po folded into MISR, LFSR advanced
  // DONE    | signature and pass valid
  typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [N_IN-1:0] SEED_EFF =
    (LFSR_SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : LFSR_SEED;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [N_IN-1:0]  pi_q, pi_d;
  logic [N_OUT-1:0] misr_q, misr_d, misr_next;
  logic [N_OUT-1:0] sig_q, sig_d;
  logic [15:0]      pat_q, pat_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             pass_q, pass_d;

  always_comb begin
    lfsr_next = {lfsr_q[N_IN-2:0], 1'b0} ^ (lfsr_q[N_IN-1] ? LFSR_POLY : '0);
    misr_next = {misr_q[N_OUT-2:0], 1'b0} ^ (misr_q[N_OUT-1] ? MISR_POLY : '0) ^ po;
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    pi_d     = pi_q;
    misr_d   = misr_q;
    sig_d    = sig_q;
    pat_d    = pat_q;
    settle_d = settle_q;
    pass_d   = pass_q;
    if (abort) begin
      state_d = IDLE;
      pi_d    = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            lfsr_d   = SEED_EFF;
            pi_d     = SEED_EFF;
            misr_d   = '0;
            pat_d    = '0;
            settle_d = '0;
            pass_d   = 1'b0;
            state_d  = APPLY;
          end
        end
        APPLY: begin
          if (settle_q == SW'(SETTLE - 1)) begin
            settle_d = '0;
            state_d  = CAPTURE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        CAPTURE: begin
          misr_d = misr_next;
          lfsr_d = lfsr_next;
          pi_d   = lfsr_next;
          if (pat_q == 16'(N_PAT - 1)) begin
            sig_d   = misr_next;
            pass_d  = (misr_next == exp_sig);
            state_d = DONE;
          end else begin
            pat_d   = pat_q + 16'd1;
            state_d = APPLY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      pi_q     <= '0;
      misr_q   <= '0;
      sig_q    <= '0;
      pat_q    <= '0;
      settle_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      pi_q     <= pi_d;
      misr_q   <= misr_d;
      sig_q    <= sig_d;
      pat_q    <= pat_d;
      settle_q <= settle_d;
      pass_q   <= pass_d;
    end
  end

  assign pi        = pi_q;
  assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
  assign done      = (state_q == DONE);
  assign signature = sig_q;
  assign pass      = pass_q && (state_q == DONE);

endmodule
